cu_pipe: RTL and testbench

CU_PIPE -- requirements
Module: cu_pipe

---
 rtl/cu_pipe.sv | 279 +++++++++++++++++++++++++++
 tb/tb_cu_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_pipe.sv
// Pipelined RV32I control unit: decodes an accepted instruction into a registered
// control bundle, with valid/ready handshake, flush and a load-use hazard stall.
`timescale 1ns/1ps

`ifndef CU_PIPE_DEFS
`define CU_PIPE_DEFS
`define INST_WIDTH                32
`define IMMEDIATE_SELECTION_WIDTH 3
`define NOP_TYPE                  3'd0
`define I_TYPE                    3'd1
`define S_TYPE                    3'd2
`define B_TYPE                    3'd3
`define U_TYPE                    3'd4
`define J_TYPE                    3'd5
`define MEMORY_MODE_WIDTH         3
`define NOP_MEMORY_MODE           3'd0
`define BYTE_MEMORY_MODE          3'd1
`define HALF_MEMORY_MODE          3'd2
`define WORD_MEMORY_MODE          3'd3
`define UBYTE_MEMORY_MODE         3'd4
`define UHALF_MEMORY_MODE         3'd5
`endif

module cu_pipe #(
    parameter int LOAD_LATENCY   = 1,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [`INST_WIDTH-1:0]                instruction,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  flush,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [`IMMEDIATE_SELECTION_WIDTH-1:0] imm_type,
    output logic                                  D_MEM_write,
    output logic                                  D_MEM_read,
    output logic [`MEMORY_MODE_WIDTH-1:0]         D_MEM_mode,
    output logic                                  RF_write,
    output logic                                  RS2_IMM_ALU_SRC_MUX_sel,
    output logic                                  DMEM_ALU_WB_MUX_sel,
    output logic                                  branch,
    output logic                                  jump,
    output logic                                  jalr,
    output logic [REG_ADDR_WIDTH-1:0]             rd,
    output logic [REG_ADDR_WIDTH-1:0]             rs1,
    output logic [REG_ADDR_WIDTH-1:0]             rs2,
    output logic                                  illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [1:0] LAT        = 2'(LOAD_LATENCY);

    typedef struct packed {
        logic [`IMMEDIATE_SELECTION_WIDTH-1:0] imm_type;
        logic                                  mem_write;
        logic                                  mem_read;
        logic [`MEMORY_MODE_WIDTH-1:0]         mem_mode;
        logic                                  rf_write;
        logic                                  alu_src;
        logic                                  wb_sel;
        logic                                  branch;
        logic                                  jump;
        logic                                  jalr;
        logic                                  illegal;
    } ctl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd_f;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;

    assign opcode = instruction[6:0];
    assign rd_f   = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1_f  = instruction[19:15];
    assign rs2_f  = instruction[24:20];
    assign funct7 = instruction[31:25];

    ctl_t ctl;
    ctl_t ctl_q;
    logic legal;
    logic wr;
    logic rd_rs1;
    logic rd_rs2;
    logic is_load;

    always_comb begin
        ctl          = '0;
        ctl.imm_type = `NOP_TYPE;
        ctl.mem_mode = `NOP_MEMORY_MODE;
        legal        = 1'b0;
        wr           = 1'b0;
        rd_rs1       = 1'b0;
        rd_rs2       = 1'b0;
        is_load      = 1'b0;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal        = 1'b1;
                wr           = 1'b1;
                ctl.imm_type = `U_TYPE;
                ctl.alu_src  = 1'b1;
            end
            OPC_JAL: begin
                legal        = 1'b1;
                wr           = 1'b1;
                ctl.imm_type = `J_TYPE;
                ctl.jump     = 1'b1;
            end
            OPC_JALR: begin
                legal        = (funct3 == 3'b000);
                wr           = 1'b1;
                rd_rs1       = 1'b1;
                ctl.imm_type = `I_TYPE;
                ctl.alu_src  = 1'b1;
                ctl.jalr     = 1'b1;
            end
            OPC_BRANCH: begin
                legal        = (funct3 != 3'b010) && (funct3 != 3'b011);
                rd_rs1       = 1'b1;
                rd_rs2       = 1'b1;
                ctl.imm_type = `B_TYPE;
                ctl.branch   = 1'b1;
            end
            OPC_LOAD: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  ctl.mem_mode = `BYTE_MEMORY_MODE;
                    3'b001:  ctl.mem_mode = `HALF_MEMORY_MODE;
                    3'b010:  ctl.mem_mode = `WORD_MEMORY_MODE;
                    3'b100:  ctl.mem_mode = `UBYTE_MEMORY_MODE;
                    3'b101:  ctl.mem_mode = `UHALF_MEMORY_MODE;
                    default: legal = 1'b0;
                endcase
                wr           = 1'b1;
                rd_rs1       = 1'b1;
                is_load      = 1'b1;
                ctl.imm_type = `I_TYPE;
                ctl.mem_read = 1'b1;
                ctl.alu_src  = 1'b1;
                ctl.wb_sel   = 1'b1;
            end
            OPC_STORE: begin
                legal = 1'b1;
                case (funct3)
                    3'b000:  ctl.mem_mode = `BYTE_MEMORY_MODE;
                    3'b001:  ctl.mem_mode = `HALF_MEMORY_MODE;
                    3'b010:  ctl.mem_mode = `WORD_MEMORY_MODE;
                    default: legal = 1'b0;
                endcase
                rd_rs1        = 1'b1;
                rd_rs2        = 1'b1;
                ctl.imm_type  = `S_TYPE;
                ctl.mem_write = 1'b1;
                ctl.alu_src   = 1'b1;
            end
            OPC_OPIMM: begin
                // shift-immediates constrain funct7; other funct3 take any imm
                if (funct3 == 3'b001)
                    legal = (funct7 == F7_ZERO);
                else if (funct3 == 3'b101)
                    legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                else
                    legal = 1'b1;
                wr           = 1'b1;
                rd_rs1       = 1'b1;
                ctl.imm_type = `I_TYPE;
                ctl.alu_src  = 1'b1;
            end
            OPC_OP: begin
                legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == 3'b000) || (funct3 == 3'b101)));
                wr     = 1'b1;
                rd_rs1 = 1'b1;
                rd_rs2 = 1'b1;
            end
            OPC_FENCE: legal = (funct3 == 3'b000);
            OPC_SYSTEM: begin
                legal = (instruction == 32'h0000_0073) ||
                        (instruction == 32'h0010_0073);
            end
            default: legal = 1'b0;
        endcase
        ctl.rf_write = wr & (rd_f != 5'd0);
        if (!legal) begin
            ctl          = '0;
            ctl.imm_type = `NOP_TYPE;
            ctl.mem_mode = `NOP_MEMORY_MODE;
            ctl.illegal  = 1'b1;
            rd_rs1       = 1'b0;
            rd_rs2       = 1'b0;
            is_load      = 1'b0;
        end
    end

    logic [1:0]                cnt;
    logic [REG_ADDR_WIDTH-1:0] last_load_rd;
    logic [REG_ADDR_WIDTH-1:0] rd_x;
    logic [REG_ADDR_WIDTH-1:0] rs1_x;
    logic [REG_ADDR_WIDTH-1:0] rs2_x;
    logic                      hazard;
    logic                      accept;

    assign rd_x  = REG_ADDR_WIDTH'(rd_f);
    assign rs1_x = REG_ADDR_WIDTH'(rs1_f);
    assign rs2_x = REG_ADDR_WIDTH'(rs2_f);

    assign hazard = (LOAD_LATENCY != 0) && (cnt != 2'd0) && in_valid &&
                    ((rd_rs1 && (rs1_x == last_load_rd)) ||
                     (rd_rs2 && (rs2_x == last_load_rd)));

    assign in_ready = !flush && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            ctl_q          <= '0;
            ctl_q.imm_type <= `NOP_TYPE;
            ctl_q.mem_mode <= `NOP_MEMORY_MODE;
            rd             <= '0;
            rs1            <= '0;
            rs2            <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctl_q     <= ctl;
            rd        <= rd_x;
            rs1       <= rs1_x;
            rs2       <= rs2_x;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= 2'd0;
            last_load_rd <= '0;
        end else if (flush) begin
            cnt <= 2'd0;
        end else if (accept && is_load && (rd_f != 5'd0)) begin
            cnt          <= LAT;
            last_load_rd <= rd_x;
        end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
        end
    end

    assign imm_type                = ctl_q.imm_type;
    assign D_MEM_write             = ctl_q.mem_write;
    assign D_MEM_read              = ctl_q.mem_read;
    assign D_MEM_mode              = ctl_q.mem_mode;
    assign RF_write                = ctl_q.rf_write;
    assign RS2_IMM_ALU_SRC_MUX_sel = ctl_q.alu_src;
    assign DMEM_ALU_WB_MUX_sel     = ctl_q.wb_sel;
    assign branch                  = ctl_q.branch;
    assign jump                    = ctl_q.jump;
    assign jalr                    = ctl_q.jalr;
    assign illegal                 = ctl_q.illegal;

endmodule

// File: tb/tb_cu_pipe.sv
// Directed bench for cu_pipe: decode, load-use stall, backpressure,
// flush and asynchronous reset.
`timescale 1ns/1ps

`ifndef CU_PIPE_DEFS
`define CU_PIPE_DEFS
`define INST_WIDTH                32
`define IMMEDIATE_SELECTION_WIDTH 3
`define NOP_TYPE                  3'd0
`define I_TYPE                    3'd1
`define S_TYPE                    3'd2
`define B_TYPE                    3'd3
`define U_TYPE                    3'd4
`define J_TYPE                    3'd5
`define MEMORY_MODE_WIDTH         3
`define NOP_MEMORY_MODE           3'd0
`define BYTE_MEMORY_MODE          3'd1
`define HALF_MEMORY_MODE          3'd2
`define WORD_MEMORY_MODE          3'd3
`define UBYTE_MEMORY_MODE         3'd4
`define UHALF_MEMORY_MODE         3'd5
`endif

module tb_cu_pipe;

    localparam logic [31:0] LW    = 32'h0000_A283;
    localparam logic [31:0] ADD   = 32'h0052_8333;
    localparam logic [31:0] ADDI5 = 32'h0050_0313;
    localparam logic [31:0] LUI   = 32'h0002_8337;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] BAD   = 32'hFFFF_FFFF;
    localparam logic [31:0] AUIPC = 32'h0000_0297;
    localparam logic [31:0] SRAI  = 32'h4010_D093;
    localparam logic [31:0] SW    = 32'h0011_2023;
    localparam logic [31:0] LI1   = 32'h0010_0093;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  imm_type;
    logic        D_MEM_write;
    logic        D_MEM_read;
    logic [2:0]  D_MEM_mode;
    logic        RF_write;
    logic        alu_src;
    logic        wb_sel;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        illegal;

    int passed = 0;
    int total  = 0;

    cu_pipe #(.LOAD_LATENCY(1), .REG_ADDR_WIDTH(5)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .instruction             (instruction),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .flush                   (flush),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .imm_type                (imm_type),
        .D_MEM_write             (D_MEM_write),
        .D_MEM_read              (D_MEM_read),
        .D_MEM_mode              (D_MEM_mode),
        .RF_write                (RF_write),
        .RS2_IMM_ALU_SRC_MUX_sel (alu_src),
        .DMEM_ALU_WB_MUX_sel     (wb_sel),
        .branch                  (branch),
        .jump                    (jump),
        .jalr                    (jalr),
        .rd                      (rd),
        .rs1                     (rs1),
        .rs2                     (rs2),
        .illegal                 (illegal)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    logic [14:0] ctl_all;
    assign ctl_all = {imm_type, D_MEM_write, D_MEM_read, D_MEM_mode,
                      RF_write, alu_src, wb_sel, branch, jump, jalr};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst_n       = 1'b0;
        instruction = '0;
        in_valid    = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b1;

        #5;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_imm_type", 32'(imm_type), 32'(`NOP_TYPE));
        chk("rst_mem_mode", 32'(D_MEM_mode), 32'(`NOP_MEMORY_MODE));
        chk("rst_ctl_all", 32'(ctl_all), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw x5 then dependent add: one stall cycle
        @(negedge clk);
        instruction = LW;
        in_valid    = 1'b1;
        #1 chk("lw_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        chk("lw_out_valid", 32'(out_valid), 1);
        chk("lw_mem_read", 32'(D_MEM_read), 1);
        chk("lw_wb_sel", 32'(wb_sel), 1);
        chk("lw_mode", 32'(D_MEM_mode), 32'(`WORD_MEMORY_MODE));
        chk("lw_rd", 32'(rd), 5);
        instruction = ADD;
        #1 chk("hazard_stall", 32'(in_ready), 0);
        @(negedge clk);
        chk("bubble_out_valid", 32'(out_valid), 0);
        #1 chk("stall_released", 32'(in_ready), 1);
        @(negedge clk);
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_rf_write", 32'(RF_write), 1);
        chk("add_rd", 32'(rd), 6);
        chk("add_rs", 32'({rs1, rs2}), 32'({5'd5, 5'd5}));
        chk("add_alu_src", 32'(alu_src), 0);

        // I-type reads only rs1; rs2 field matching the load rd is ignored
        instruction = LW;
        @(negedge clk);
        instruction = ADDI5;
        #1 chk("itype_no_hazard", 32'(in_ready), 1);
        @(negedge clk);
        chk("addi_rd", 32'(rd), 6);
        chk("addi_imm", 32'(imm_type), 32'(`I_TYPE));

        // LUI reads no register
        instruction = LW;
        @(negedge clk);
        instruction = LUI;
        #1 chk("lui_no_hazard", 32'(in_ready), 1);
        @(negedge clk);
        chk("lui_imm", 32'(imm_type), 32'(`U_TYPE));
        chk("lui_rf_write", 32'(RF_write), 1);

        instruction = NOP;
        @(negedge clk);
        chk("nop_alu_src", 32'(alu_src), 1);
        chk("nop_imm", 32'(imm_type), 32'(`I_TYPE));
        chk("nop_rf_write_x0", 32'(RF_write), 0);
        chk("nop_illegal", 32'(illegal), 0);

        instruction = BAD;
        @(negedge clk);
        chk("bad_illegal", 32'(illegal), 1);
        chk("bad_ctl_zero", 32'(ctl_all), 0);
        chk("bad_out_valid", 32'(out_valid), 1);

        instruction = AUIPC;
        @(negedge clk);
        chk("auipc_imm", 32'(imm_type), 32'(`U_TYPE));
        chk("auipc_alu_src", 32'(alu_src), 1);
        chk("auipc_rf_write", 32'(RF_write), 1);

        instruction = SRAI;
        @(negedge clk);
        chk("srai_imm", 32'(imm_type), 32'(`I_TYPE));
        chk("srai_alu_src", 32'(alu_src), 1);
        chk("srai_illegal", 32'(illegal), 0);

        // sw held under backpressure for three cycles
        instruction = SW;
        @(negedge clk);
        out_ready   = 1'b0;
        instruction = LI1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_out_valid", 32'(out_valid), 1);
            chk("bp_mem_write", 32'(D_MEM_write), 1);
            chk("bp_mode", 32'(D_MEM_mode), 32'(`WORD_MEMORY_MODE));
            chk("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release", 32'(in_ready), 1);
        @(negedge clk);
        chk("li_rd", 32'(rd), 1);
        chk("li_rf_write", 32'(RF_write), 1);
        chk("li_mem_write", 32'(D_MEM_write), 0);

        // flush right after the lw clears the pending stall
        instruction = LW;
        @(negedge clk);
        chk("fl_lw_valid", 32'(out_valid), 1);
        flush       = 1'b1;
        instruction = ADD;
        #1 chk("fl_no_accept", 32'(in_ready), 0);
        @(negedge clk);
        flush = 1'b0;
        chk("fl_out_valid", 32'(out_valid), 0);
        #1 chk("fl_no_stall", 32'(in_ready), 1);
        @(negedge clk);
        chk("fl_add_valid", 32'(out_valid), 1);
        chk("fl_add_rd", 32'(rd), 6);

        // async reset while the stall counter is armed
        instruction = LW;
        @(negedge clk);
        instruction = ADD;
        #1 chk("ar_lw_valid", 32'(out_valid), 1);
        #2 rst_n = 1'b0;
        #2;
        chk("ar_out_valid", 32'(out_valid), 0);
        chk("ar_ctl_zero", 32'(ctl_all), 0);
        chk("ar_rd", 32'(rd), 0);
        #2 rst_n = 1'b1;
        #1 chk("ar_no_stall", 32'(in_ready), 1);
        @(negedge clk);
        chk("ar_add_valid", 32'(out_valid), 1);
        chk("ar_add_rd", 32'(rd), 6);
        chk("ar_add_rf_write", 32'(RF_write), 1);

        in_valid = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", 32'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
